// File: rtl/rr_stream_mux.sv
// Registered NCH-to-1 stream mux: fixed-select or round-robin channel choice
// feeding a single-entry output register with a wrapping handshake counter.
module rr_stream_mux #(
    parameter int NCH = 8,
    parameter int DW  = 8,
    parameter int SW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SW-1:0]     out_ch,
    output logic [15:0]       xfer_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    localparam logic [SW:0]   NCH_W = (SW+1)'(NCH);
    localparam logic [SW-1:0] LAST  = SW'(NCH - 1);

    state_e        state_q;
    logic [DW-1:0] data_q;
    logic [SW-1:0] ch_q;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [15:0]   cnt_q;

    logic [NCH-1:0][DW-1:0] ch_data;
    logic                   load_en, in_xfer, out_xfer;
    logic                   rr_hit, pick_vld;
    logic [SW-1:0]          rr_c, pick_c;
    logic [SW:0]            idx;

    assign ch_data = in_data;
    assign load_en = (state_q == EMPTY) || out_ready;

    // Circular search starting at ptr; idx is one bit wider so ptr+k never overflows before wrap.
    always_comb begin
        rr_hit = 1'b0;
        rr_c   = '0;
        idx    = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = {1'b0, ptr_q} + (SW+1)'(k);
            if (idx >= NCH_W) idx = idx - NCH_W;
            if (!rr_hit && in_valid[idx[SW-1:0]]) begin
                rr_hit = 1'b1;
                rr_c   = idx[SW-1:0];
            end
        end
    end

    assign pick_vld = mode ? rr_hit : ({1'b0, sel} < NCH_W);
    assign pick_c   = mode ? rr_c : sel;

    always_comb begin
        in_ready = '0;
        if (pick_vld) in_ready[pick_c] = load_en;
    end

    assign in_xfer  = pick_vld && load_en && in_valid[pick_c];
    assign out_xfer = (state_q == FULL) && out_ready;
    assign ptr_d    = (pick_c == LAST) ? '0 : pick_c + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (out_xfer) cnt_q <= cnt_q + 16'd1;
            if (in_xfer) begin
                state_q <= FULL;
                data_q  <= ch_data[pick_c];
                ch_q    <= pick_c;
                if (mode) ptr_q <= ptr_d;
            end else if (out_xfer) begin
                state_q <= EMPTY;
            end
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: vector table, directed corner sequences and a
// randomized run against a queue-free behavioural model.
module tb_rr_stream_mux;
    localparam int NCH = 8;
    localparam int DW  = 8;
    localparam int SW  = 3;

    logic              clk, rst_n;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_valid, in_ready;
    logic              mode, out_valid, out_ready;
    logic [SW-1:0]     sel, out_ch;
    logic [DW-1:0]     out_data;
    logic [15:0]       xfer_cnt;

    rr_stream_mux #(.NCH(NCH), .DW(DW), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .xfer_cnt(xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pattern();
        for (int i = 0; i < NCH; i++) in_data[i*DW +: DW] = 8'hA0 | 8'(i);
    endtask

    // Behavioural model state
    logic        m_full;
    logic [7:0]  m_data;
    int          m_ch;
    int          m_ptr;
    logic [15:0] m_cnt;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        m_full = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0; m_cnt = '0;
    endtask

    function automatic int model_pick();
        if (!mode) return (int'(sel) < NCH) ? int'(sel) : -1;
        for (int k = 0; k < NCH; k++)
            if (in_valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
        return -1;
    endfunction

    task automatic model_cycle();
        int         c;
        bit         load, ix, ox;
        logic [7:0] er;
        #1;
        c    = model_pick();
        load = !m_full || out_ready;
        er   = '0;
        if (c >= 0 && load) er[c] = 1'b1;
        chk("rnd_in_ready", in_ready, er);
        ix = (c >= 0) && load && in_valid[c];
        ox = m_full && out_ready;
        if (ox) m_cnt = m_cnt + 16'd1;
        if (ix) begin
            m_data = in_data[c*DW +: DW];
            m_ch   = c;
            m_full = 1'b1;
            if (mode) m_ptr = (c + 1) % NCH;
        end else if (ox) begin
            m_full = 1'b0;
        end
        step();
        chk("rnd_out_valid", out_valid, m_full);
        chk("rnd_xfer_cnt", xfer_cnt, m_cnt);
        if (m_full) begin
            chk("rnd_out_ch", out_ch, m_ch);
            chk("rnd_out_data", out_data, m_data);
        end
    endtask

    typedef struct {
        logic       mode;
        logic [2:0] sel;
        logic [7:0] vld;
        logic [7:0] exp_rdy;
        logic       exp_valid;
        logic [2:0] exp_ch;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Fixed select, then round-robin from ptr=0 (mode 0 leaves ptr alone)
        vecs[0] = '{1'b0, 3'd5, 8'hFF, 8'h20, 1'b1, 3'd5};
        vecs[1] = '{1'b0, 3'd2, 8'h00, 8'h04, 1'b0, 3'd0};
        vecs[2] = '{1'b0, 3'd7, 8'h80, 8'h80, 1'b1, 3'd7};
        for (int i = 0; i < 8; i++)
            vecs[3+i] = '{1'b1, 3'd0, 8'hFF, 8'(1 << i), 1'b1, 3'(i)};
        vecs[11] = '{1'b1, 3'd0, 8'hFF, 8'h01, 1'b1, 3'd0};

        rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
        in_data = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        rst_n = 1'b1;

        // Table: first row transfers on the first edge after reset release
        set_pattern();
        out_ready = 1'b1;
        for (int r = 0; r < 12; r++) begin
            mode = vecs[r].mode; sel = vecs[r].sel; in_valid = vecs[r].vld;
            #1;
            chk($sformatf("vec%0d_in_ready", r), in_ready, vecs[r].exp_rdy);
            step();
            chk($sformatf("vec%0d_out_valid", r), out_valid, vecs[r].exp_valid);
            if (vecs[r].exp_valid) begin
                chk($sformatf("vec%0d_out_ch", r), out_ch, vecs[r].exp_ch);
                chk($sformatf("vec%0d_out_data", r), out_data, 8'hA0 | 8'(vecs[r].exp_ch));
            end
        end

        // Fairness count: 8 round-robin beats, then drain
        do_reset();
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        repeat (8) step();
        in_valid = '0;
        step();
        chk("rr8_xfer_cnt", xfer_cnt, 8);
        chk("rr8_drained", out_valid, 0);

        // Skip and wrap: land ptr on 6, then in_valid=0x09
        do_reset();
        mode = 1'b1; in_valid = 8'h20; out_ready = 1'b1;
        #1 chk("skip_first_rdy", in_ready, 8'h20);
        step();
        in_valid = 8'h09;
        #1 chk("skip_rdy_a", in_ready, 8'h01);
        step(); chk("skip_ch_a", out_ch, 0);
        chk("skip_rdy_b", in_ready, 8'h08);
        step(); chk("skip_ch_b", out_ch, 3);
        chk("skip_rdy_c", in_ready, 8'h01);
        step(); chk("skip_ch_c", out_ch, 0);

        // Backpressure with a sel change mid-stall, then reload without a bubble
        do_reset();
        set_pattern();
        in_data[3*DW +: DW] = 8'h3C;
        mode = 1'b0; sel = 3'd3; in_valid = 8'hFF; out_ready = 1'b1;
        step();
        chk("bp_load_data", out_data, 8'h3C);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) sel = 3'd4;
            #1 chk("bp_stall_rdy", in_ready, 8'h00);
            step();
            chk("bp_stall_data", out_data, 8'h3C);
            chk("bp_stall_ch", out_ch, 3);
            chk("bp_stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", in_ready, 8'h10);
        step();
        chk("bp_reload_data", out_data, 8'hA4);
        chk("bp_reload_valid", out_valid, 1);
        chk("bp_reload_cnt", xfer_cnt, 1);

        // Reset mid-operation: grants 0..7,0,1,2,3 leave ptr=4, 11 handshakes
        do_reset();
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        repeat (12) step();
        chk("mid_pre_cnt", xfer_cnt, 11);
        chk("mid_pre_ch", out_ch, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ch", out_ch, 0);
        chk("mid_rst_cnt", xfer_cnt, 0);
        #1 rst_n = 1'b1;
        #1 chk("mid_after_rdy", in_ready, 8'h01);
        step();
        chk("mid_after_ch", out_ch, 0);
        chk("mid_after_valid", out_valid, 1);

        // Counter wrap: one load edge then 65535 handshakes, then one more
        do_reset();
        mode = 1'b0; sel = 3'd0; in_valid = 8'h01; out_ready = 1'b1;
        repeat (65536) @(posedge clk);
        #1 chk("wrap_ffff", xfer_cnt, 16'hFFFF);
        step();
        chk("wrap_zero", xfer_cnt, 16'h0000);

        // Randomized run against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            mode      = ($urandom_range(0, 2) != 0);
            sel       = 3'($urandom);
            in_valid  = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            model_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
